// File: rtl/sram_masked_clr_if.sv
// Access bus of the masked-write SRAM with whole-array clear.
interface sram_masked_clr_if #(
   parameter int unsigned DATA_W = 99,
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned NSEG   = 3
) ();
   logic              csb;
   logic              wsb;
   logic [NSEG-1:0]   wmask;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W-1:0] raddr;
   logic              clr_req;
   logic              busy;
   logic [DATA_W-1:0] rdata;
   logic              rvalid;

   // Requester side
   modport master (
      output csb, wsb, wmask, wdata, waddr, raddr, clr_req,
      input  busy, rdata, rvalid
   );

   // Memory side
   modport slave (
      input  csb, wsb, wmask, wdata, waddr, raddr, clr_req,
      output busy, rdata, rvalid
   );
endinterface

// File: rtl/sram_masked_clr.sv
// Single-port-timing SRAM model: one read and one masked write per cycle,
// 1- or 2-cycle read latency, selectable read-during-write behaviour and a
// sequential whole-array clear that walks one word per cycle.
module sram_masked_clr #(
   parameter int unsigned DATA_W = 99,
   parameter int unsigned DEPTH  = 1728,
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned SEG_W  = 33,
   parameter int unsigned RD_LAT = 1,
   parameter bit          BYPASS = 1'b0
) (
   input logic               clk,
   input logic               rst,
   sram_masked_clr_if.slave  bus
);

   localparam int unsigned NSEG  = DATA_W / SEG_W;
   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic [ADDR_W-1:0] clr_cnt;
   logic [ADDR_W-1:0] clr_cnt_nxt;
   logic              busy_q;

   logic              accept_c;
   logic              rd_en_c;
   logic              wr_en_c;
   logic              clr_wr_c;
   logic              rd_in_range_c;
   logic              wr_in_range_c;
   logic [IDX_W-1:0]  rd_idx_c;
   logic [IDX_W-1:0]  wr_idx_c;
   logic [IDX_W-1:0]  clr_idx_c;
   logic [DATA_W-1:0] rd_word_c;

   logic              s1_vld;
   logic [DATA_W-1:0] s1_data;

   // Access qualification: accesses only in IDLE, a coincident clear request wins
   always_comb begin
      accept_c      = (state == ST_IDLE) && !bus.csb && !bus.clr_req && !rst;
      rd_in_range_c = 32'(bus.raddr) < DEPTH;
      wr_in_range_c = 32'(bus.waddr) < DEPTH;
      rd_en_c       = accept_c;
      wr_en_c       = accept_c && !bus.wsb && wr_in_range_c;
      clr_wr_c      = (state == ST_CLEAR);
      rd_idx_c      = IDX_W'(bus.raddr);
      wr_idx_c      = IDX_W'(bus.waddr);
      clr_idx_c     = IDX_W'(clr_cnt);
   end

   // Read word: out-of-range reads give zero; optional merge of same-cycle write
   always_comb begin
      rd_word_c = '0;
      if (rd_in_range_c) begin
         rd_word_c = mem[rd_idx_c];
      end
      for (int unsigned i = 0; i < NSEG; i++) begin
         if (BYPASS && wr_en_c && (bus.waddr == bus.raddr) && bus.wmask[i]) begin
            rd_word_c[i*SEG_W +: SEG_W] = bus.wdata[i*SEG_W +: SEG_W];
         end
      end
   end

   // Clear FSM next-state logic
   always_comb begin
      state_nxt   = state;
      clr_cnt_nxt = clr_cnt;
      case (state)
         ST_IDLE: begin
            if (bus.clr_req) begin
               state_nxt   = ST_CLEAR;
               clr_cnt_nxt = '0;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
               state_nxt   = ST_IDLE;
               clr_cnt_nxt = '0;
            end else begin
               clr_cnt_nxt = clr_cnt + ADDR_W'(1);
            end
         end
         default: begin
            state_nxt   = ST_IDLE;
            clr_cnt_nxt = '0;
         end
      endcase
   end

   // Clear FSM state, counter and busy flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         clr_cnt <= '0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         clr_cnt <= clr_cnt_nxt;
         busy_q  <= (state_nxt == ST_CLEAR);
      end
   end

   // Storage array: never reset; also written by the load_word backdoor
   always @(posedge clk) begin
      if (clr_wr_c) begin
         mem[clr_idx_c] <= '0;
      end else if (wr_en_c) begin
         for (int unsigned i = 0; i < NSEG; i++) begin
            if (bus.wmask[i]) begin
               mem[wr_idx_c][i*SEG_W +: SEG_W] <= bus.wdata[i*SEG_W +: SEG_W];
            end
         end
      end
   end

   // First read stage: data holds between reads
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_vld  <= 1'b0;
         s1_data <= '0;
      end else begin
         s1_vld <= rd_en_c;
         if (rd_en_c) begin
            s1_data <= rd_word_c;
         end
      end
   end

   generate
      if (RD_LAT == 2) begin : g_lat2
         logic              s2_vld;
         logic [DATA_W-1:0] s2_data;

         // Second output stage; in-flight reads drain even once a clear starts
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               s2_vld  <= 1'b0;
               s2_data <= '0;
            end else begin
               s2_vld <= s1_vld;
               if (s1_vld) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign bus.rdata  = s2_data;
         assign bus.rvalid = s2_vld;
      end else begin : g_lat1
         assign bus.rdata  = s1_data;
         assign bus.rvalid = s1_vld;
      end
   endgenerate

   assign bus.busy = busy_q;

   // Backdoor preload for simulation only
   task automatic load_word(input int unsigned index, input logic [DATA_W-1:0] value);
      mem[IDX_W'(index)] <= value;
   endtask

endmodule

// File: tb/tb_sram_masked_clr.sv
// Directed bench: two instances (RD_LAT=1/BYPASS=0 and RD_LAT=2/BYPASS=1)
// driven identically, checked every cycle against a reference array model
// and per-instance scoreboards of expected read results.
module tb_sram_masked_clr;

   localparam int unsigned DW = 12;
   localparam int unsigned SW = 4;
   localparam int unsigned DP = 16;
   localparam int unsigned AW = 5;
   localparam int unsigned NS = 3;

   typedef struct {
      int unsigned   due;
      logic [DW-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   sram_masked_clr_if #(.DATA_W(DW), .ADDR_W(AW), .NSEG(NS)) bus1 ();
   sram_masked_clr_if #(.DATA_W(DW), .ADDR_W(AW), .NSEG(NS)) bus2 ();

   sram_masked_clr #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .SEG_W(SW),
                     .RD_LAT(1), .BYPASS(1'b0)) u_lat1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   sram_masked_clr #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .SEG_W(SW),
                     .RD_LAT(2), .BYPASS(1'b1)) u_lat2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   always #5 clk = ~clk;

   int unsigned   n_cmp  = 0;
   int unsigned   n_bad  = 0;
   int unsigned   edge_n = 0;
   exp_t          q1[$];
   exp_t          q2[$];
   logic [DW-1:0] hold [2];
   logic [DW-1:0] ref_mem [DP];
   logic          m_busy = 1'b0;
   int unsigned   m_cnt  = 0;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic csb, input logic wsb, input logic [NS-1:0] wmask,
                        input logic [DW-1:0] wdata, input logic [AW-1:0] waddr,
                        input logic [AW-1:0] raddr, input logic clr);
      bus1.csb = csb;  bus1.wsb = wsb;  bus1.wmask = wmask;  bus1.wdata = wdata;
      bus1.waddr = waddr;  bus1.raddr = raddr;  bus1.clr_req = clr;
      bus2.csb = csb;  bus2.wsb = wsb;  bus2.wmask = wmask;  bus2.wdata = wdata;
      bus2.waddr = waddr;  bus2.raddr = raddr;  bus2.clr_req = clr;
   endtask

   task automatic check_dut(input int d, input logic busy, input logic rvalid,
                            input logic [DW-1:0] rdata);
      logic          ev;
      logic [DW-1:0] ed;
      string         pfx;
      ev  = 1'b0;
      ed  = '0;
      pfx = (d == 0) ? "lat1" : "lat2";
      if (d == 0) begin
         if (q1.size() > 0 && q1[0].due == edge_n) begin
            ev = 1'b1;  ed = q1[0].data;  void'(q1.pop_front());
         end
      end else begin
         if (q2.size() > 0 && q2[0].due == edge_n) begin
            ev = 1'b1;  ed = q2[0].data;  void'(q2.pop_front());
         end
      end
      if (ev) hold[d] = ed;
      cmp({pfx, "_busy"},   32'(busy),   32'(m_busy));
      cmp({pfx, "_rvalid"}, 32'(rvalid), 32'(ev));
      cmp({pfx, "_rdata"},  32'(rdata),  32'(hold[d]));
   endtask

   // One clock: drive, advance the model, then check both instances at the falling edge
   task automatic step(input logic csb, input logic wsb, input logic [NS-1:0] wmask,
                       input logic [DW-1:0] wdata, input logic [AW-1:0] waddr,
                       input logic [AW-1:0] raddr, input logic clr);
      logic [DW-1:0] old_w;
      logic [DW-1:0] byp_w;
      exp_t          e;
      drive(csb, wsb, wmask, wdata, waddr, raddr, clr);
      if (m_busy) begin
         ref_mem[m_cnt] = '0;
         if (m_cnt == DP - 1) begin
            m_busy = 1'b0;  m_cnt = 0;
         end else begin
            m_cnt++;
         end
      end else if (clr) begin
         m_busy = 1'b1;
         m_cnt  = 0;
      end else if (!csb) begin
         old_w = (32'(raddr) < DP) ? ref_mem[raddr[3:0]] : '0;
         byp_w = old_w;
         if (!wsb && 32'(waddr) < DP && waddr == raddr) begin
            for (int s = 0; s < int'(NS); s++)
               if (wmask[s]) byp_w[s*SW +: SW] = wdata[s*SW +: SW];
         end
         e.due = edge_n + 1;  e.data = old_w;  q1.push_back(e);
         e.due = edge_n + 2;  e.data = byp_w;  q2.push_back(e);
         if (!wsb && 32'(waddr) < DP) begin
            for (int s = 0; s < int'(NS); s++)
               if (wmask[s]) ref_mem[waddr[3:0]][s*SW +: SW] = wdata[s*SW +: SW];
         end
      end
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      check_dut(0, bus1.busy, bus1.rvalid, bus1.rdata);
      check_dut(1, bus2.busy, bus2.rvalid, bus2.rdata);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b1, 1'b1, '0, '0, '0, '0, 1'b0);
   endtask

   task automatic read(input logic [AW-1:0] a);
      step(1'b0, 1'b1, '0, '0, '0, a, 1'b0);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must drop before any edge
   task automatic apply_reset();
      rst = 1'b1;
      #1;
      cmp("rst_busy1",   32'(bus1.busy),   32'd0);
      cmp("rst_rvalid1", 32'(bus1.rvalid), 32'd0);
      cmp("rst_rdata1",  32'(bus1.rdata),  32'd0);
      cmp("rst_busy2",   32'(bus2.busy),   32'd0);
      cmp("rst_rvalid2", 32'(bus2.rvalid), 32'd0);
      cmp("rst_rdata2",  32'(bus2.rdata),  32'd0);
      q1.delete();
      q2.delete();
      hold[0] = '0;
      hold[1] = '0;
      m_busy  = 1'b0;
      m_cnt   = 0;
      drive(1'b1, 1'b1, '0, '0, '0, '0, 1'b0);
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic preload();
      logic [DW-1:0] v;
      for (int i = 0; i < int'(DP); i++) begin
         v = 12'(i * 12'h135 + 12'h2A7);
         if (i == 3)  v = 12'hABC;
         if (i == 5)  v = 12'h111;
         if (i == 10) v = 12'h5A5;
         ref_mem[i] = v;
         u_lat1.load_word(i, v);
         u_lat2.load_word(i, v);
      end
   endtask

   initial begin
      drive(1'b1, 1'b1, '0, '0, '0, '0, 1'b0);
      @(negedge clk);
      apply_reset();
      preload();

      // Masked write then read back: ABC with segment 1 <- 2 gives A2C
      step(1'b0, 1'b0, 3'b010, 12'h123, 5'd3, 5'd0, 1'b0);
      idle(2);
      read(5'd3);
      idle(3);

      // Read-during-write on the same address, then a later read
      step(1'b0, 1'b0, 3'b111, 12'h222, 5'd5, 5'd5, 1'b0);
      read(5'd5);
      idle(3);

      // Partial-mask read-during-write
      step(1'b0, 1'b0, 3'b101, 12'h9E7, 5'd7, 5'd7, 1'b0);
      read(5'd7);
      idle(3);

      // Out-of-range write dropped, out-of-range read gives zero
      step(1'b0, 1'b0, 3'b111, 12'hFFF, 5'd20, 5'd0, 1'b0);
      read(5'd20);
      idle(3);

      // Back-to-back reads 0-3, then a full scan of the array
      for (int a = 0; a < 4; a++) read(5'(a));
      idle(3);
      for (int a = 0; a < int'(DP); a++) read(5'(a));
      idle(3);

      // Read in flight when the clear starts, clear coinciding with a read,
      // accesses and clr_req ignored throughout the clear
      read(5'd4);
      step(1'b0, 1'b1, '0, '0, '0, 5'd2, 1'b1);
      for (int k = 0; k < int'(DP); k++)
         step(1'b0, 1'b0, 3'b111, 12'hFFF, 5'(k), 5'(k), 1'b1);
      for (int a = 0; a < int'(DP); a++) read(5'(a));
      idle(3);

      // Reset five words into a clear: aborted, remaining words untouched
      preload();
      step(1'b1, 1'b1, '0, '0, '0, '0, 1'b1);
      idle(5);
      apply_reset();
      for (int a = 0; a < int'(DP); a++) read(5'(a));
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
